// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and load/store, one transaction in flight.
// Define ARB_TIMEOUT_EN to add a REQ/RESP watchdog that aborts the transfer and pulses err_o.
module mem_port_arbiter #(
   parameter int WIDTH           = 32,
   parameter int MAX_DATA_GRANTS = 4,
   parameter int TIMEOUT_CYCLES  = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             if_req_i,
   input  logic [WIDTH-1:0] if_addr_i,
   output logic             if_gnt_o,
   output logic             if_rvalid_o,
   output logic [WIDTH-1:0] if_rdata_o,
   input  logic             dm_req_i,
   input  logic             dm_we_i,
   input  logic [WIDTH-1:0] dm_addr_i,
   input  logic [WIDTH-1:0] dm_wdata_i,
   input  logic [3:0]       dm_wmask_i,
   output logic             dm_gnt_o,
   output logic             dm_rvalid_o,
   output logic [WIDTH-1:0] dm_rdata_o,
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic [WIDTH-1:0] mem_addr_o,
   output logic [WIDTH-1:0] mem_wdata_o,
   output logic [3:0]       mem_wmask_o,
   input  logic             mem_ready_i,
   input  logic             mem_rvalid_i,
   input  logic [WIDTH-1:0] mem_rdata_i,
   output logic             busy_o,
   output logic             err_o
);
   localparam int CW = $clog2(MAX_DATA_GRANTS) + 1;
   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
   state_t state_q, state_d;
   logic own_dm_q, own_dm_d, we_q, we_d, pick_dm, to_hit;
   logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d, rd;
   logic [3:0] wmask_q, wmask_d;
   logic [CW-1:0] cnt_q, cnt_d;
   assign pick_dm = dm_req_i & (~if_req_i | (cnt_q < CW'(MAX_DATA_GRANTS)));
`ifdef ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] wait_q, wait_d;
   assign to_hit = ((state_q == REQ && !mem_ready_i) || (state_q == RESP && !mem_rvalid_i)) && wait_q == TW'(TIMEOUT_CYCLES);
   assign wait_d = (state_q == IDLE || state_d != state_q) ? '0 : wait_q + 1'b1;
   always_ff @(posedge clk_i) wait_q <= rst_i ? '0 : wait_d;
`else
   // watchdog compiled out: the limit only feeds a constant-false abort
   assign to_hit = TIMEOUT_CYCLES < 0;
`endif
   assign err_o       = to_hit;
   assign mem_req_o   = state_q == REQ;
   assign mem_we_o    = mem_req_o & we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_wmask_o = wmask_q;
   assign busy_o      = state_q != IDLE;
   assign if_rdata_o  = if_rdata_d;
   assign dm_rdata_o  = dm_rdata_d;
   always_comb begin
      state_d = state_q;
      own_dm_d = own_dm_q;
      addr_d = addr_q;
      we_d = we_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      cnt_d = cnt_q;
      if_gnt_o = 1'b0;
      dm_gnt_o = 1'b0;
      if_rvalid_o = 1'b0;
      dm_rvalid_o = 1'b0;
      rd = mem_rdata_i;
      case (state_q)
         IDLE: if (if_req_i | dm_req_i) begin
            state_d = REQ;
            own_dm_d = pick_dm;
            addr_d = pick_dm ? dm_addr_i : if_addr_i;
            we_d = pick_dm & dm_we_i;
            wdata_d = pick_dm ? dm_wdata_i : '0;
            wmask_d = pick_dm ? dm_wmask_i : '0;
            if (!if_req_i) cnt_d = '0;
         end
         REQ: if (mem_ready_i) begin
            state_d = we_q ? IDLE : RESP;
            if_gnt_o = ~own_dm_q;
            dm_gnt_o = own_dm_q;
            cnt_d = !own_dm_q ? '0 : (if_req_i && cnt_q < CW'(MAX_DATA_GRANTS)) ? cnt_q + 1'b1 : cnt_q;
         end
         RESP: if (mem_rvalid_i) begin
            state_d = IDLE;
            if_rvalid_o = ~own_dm_q;
            dm_rvalid_o = own_dm_q;
         end
         default: state_d = IDLE;
      endcase
      if (to_hit) begin
         state_d = IDLE;
         if_gnt_o = ~own_dm_q;
         dm_gnt_o = own_dm_q;
         if_rvalid_o = ~own_dm_q & ~we_q;
         dm_rvalid_o = own_dm_q & ~we_q;
         rd = '0;
      end
      if_rdata_d = if_rvalid_o ? rd : if_rdata_q;
      dm_rdata_d = dm_rvalid_o ? rd : dm_rdata_q;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         own_dm_q <= 1'b0;
         addr_q <= '0;
         we_q <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
         cnt_q <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         own_dm_q <= own_dm_d;
         addr_q <= addr_d;
         we_q <= we_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         cnt_q <= cnt_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven arbitration vectors, directed corner sequences and a randomized run against a transaction model.
module tb_mem_port_arbiter;
   localparam int MAXG = 4;
`ifdef ARB_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 64;
`endif
   logic clk_i = 1'b0, rst_i = 1'b1;
   logic if_req_i = 0, if_gnt_o, if_rvalid_o;
   logic [31:0] if_addr_i = 0, if_rdata_o;
   logic dm_req_i = 0, dm_we_i = 0, dm_gnt_o, dm_rvalid_o;
   logic [31:0] dm_addr_i = 0, dm_wdata_i = 0, dm_rdata_o;
   logic [3:0] dm_wmask_i = 0, mem_wmask_o;
   logic mem_req_o, mem_we_o, mem_ready_i = 0, mem_rvalid_i = 0, busy_o, err_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = 0;
   int n_chk = 0, n_fail = 0;

   always #5 clk_i = ~clk_i;

   mem_port_arbiter #(.WIDTH(32), .MAX_DATA_GRANTS(MAXG), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_wmask_i(dm_wmask_i),
      .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
      .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o), .err_o(err_o));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step;
      @(negedge clk_i);
   endtask

   typedef struct packed {logic ifr; logic dmr; logic we; logic exp_dm;} vec_t;
   vec_t tbl [15];

   function automatic vec_t v(input logic a, input logic b, input logic c, input logic d);
      return '{a, b, c, d};
   endfunction

   // transaction-level reference state for the random run
   int ph, wt, cnt;
   logic m_dm, e_we, gi, gd, egi, egd, eri, erd, win;
   logic [31:0] e_addr, e_wdata, last_if, last_dm;
   logic [3:0] e_mask;

   initial begin
      // both held: four data grants, then fetch; an arbitration without fetch clears the count
      tbl = '{v(1,1,0,1), v(1,1,1,1), v(1,1,0,1), v(1,1,0,1), v(1,1,0,0),
              v(1,1,0,1), v(1,1,1,1), v(1,1,0,1), v(0,1,0,1), v(1,1,0,1),
              v(1,1,0,1), v(1,1,1,1), v(1,1,0,1), v(1,1,0,0), v(1,0,0,0)};
      step;
      step;
      #1;
      chk("rst_ctl", {if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o, mem_req_o, mem_we_o, busy_o, err_o, mem_wmask_o}, 0);
      chk("rst_rdata", {if_rdata_o, dm_rdata_o}, 0);
      chk("rst_mem", {mem_addr_o, mem_wdata_o}, 0);
      rst_i = 0;
      step;
      // single fetch
      if_req_i = 1; if_addr_i = 32'h40;
      step;
      #1 chk("fetch_req", {mem_req_o, mem_we_o, busy_o, mem_addr_o}, {3'b101, 32'h40});
      mem_ready_i = 1;
      #1 chk("fetch_gnt", {if_gnt_o, dm_gnt_o}, 2'b10);
      step;
      mem_ready_i = 0; if_req_i = 0;
      #1 chk("fetch_wait", {mem_req_o, if_rvalid_o, busy_o}, 3'b001);
      step;
      mem_rvalid_i = 1; mem_rdata_i = 32'h00500093;
      #1 chk("fetch_rv", {if_rvalid_o, dm_rvalid_o, if_rdata_o}, {2'b10, 32'h00500093});
      step;
      mem_rvalid_i = 0; mem_rdata_i = 0;
      #1 chk("fetch_done", {busy_o, if_rvalid_o, if_rdata_o}, {2'b00, 32'h00500093});
      // store
      dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h100; dm_wdata_i = 32'hDEADBEEF; dm_wmask_i = 4'b0011;
      step;
      #1 chk("st_port", {mem_req_o, mem_we_o, mem_wmask_o, mem_addr_o}, {2'b11, 4'b0011, 32'h100});
      chk("st_wdata", mem_wdata_o, 32'hDEADBEEF);
      mem_ready_i = 1;
      #1 chk("st_gnt", {dm_gnt_o, if_gnt_o}, 2'b10);
      step;
      mem_ready_i = 0; dm_req_i = 0; dm_we_i = 0; mem_rvalid_i = 1;
      for (int k = 0; k < 3; k++) begin
         #1 chk("st_norv", {dm_rvalid_o, if_rvalid_o, busy_o}, 0);
         step;
      end
      mem_rvalid_i = 0;
      for (int i = 0; i < 15; i++) begin
         if_req_i = tbl[i].ifr; if_addr_i = 32'h1000 + 32'(i * 4);
         dm_req_i = tbl[i].dmr; dm_we_i = tbl[i].we; dm_addr_i = 32'h2000 + 32'(i * 4);
         dm_wdata_i = 32'(i); dm_wmask_i = 4'hF;
         step;
         #1 chk("tbl_addr", mem_addr_o, tbl[i].exp_dm ? dm_addr_i : if_addr_i);
         chk("tbl_we", {mem_req_o, mem_we_o}, {1'b1, tbl[i].exp_dm & tbl[i].we});
         mem_ready_i = 1;
         #1 chk("tbl_gnt", {if_gnt_o, dm_gnt_o}, {~tbl[i].exp_dm, tbl[i].exp_dm});
         step;
         mem_ready_i = 0;
         if (tbl[i].exp_dm) dm_req_i = 0; else if_req_i = 0;
         if (!(tbl[i].exp_dm & tbl[i].we)) begin
            mem_rvalid_i = 1; mem_rdata_i = 32'hA000 + 32'(i);
            #1 chk("tbl_rv", {if_rvalid_o, dm_rvalid_o}, {~tbl[i].exp_dm, tbl[i].exp_dm});
            chk("tbl_rdata", tbl[i].exp_dm ? dm_rdata_o : if_rdata_o, 32'hA000 + 32'(i));
            step;
            mem_rvalid_i = 0;
         end
      end
      if_req_i = 0; dm_req_i = 0; dm_we_i = 0;
      // ready withheld, then reset while waiting for read data
      dm_req_i = 1; dm_addr_i = 32'h200;
      step;
      for (int k = 0; k < 5; k++) begin
         #1 chk("hold_req", {mem_req_o, dm_gnt_o, if_gnt_o, mem_addr_o}, {3'b100, 32'h200});
         step;
      end
      mem_ready_i = 1;
      #1 chk("hold_gnt", dm_gnt_o, 1);
      step;
      mem_ready_i = 0; dm_req_i = 0;
      #1 chk("rst_resp_pre", {busy_o, mem_req_o}, 2'b10);
      rst_i = 1;
      step;
      rst_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h12345678;
      #1 chk("rst_resp_ctl", {dm_rvalid_o, if_rvalid_o, busy_o, mem_req_o, dm_gnt_o}, 0);
      chk("rst_resp_data", {mem_addr_o, dm_rdata_o}, 0);
      step;
      mem_rvalid_i = 0;
      #1 chk("rst_resp_after", {busy_o, dm_rvalid_o}, 0);
      // read whose data never arrives
      dm_req_i = 1; dm_addr_i = 32'h300;
      step;
      mem_ready_i = 1;
      step;
      mem_ready_i = 0; dm_req_i = 0; mem_rdata_i = 32'hFFFFFFFF;
      for (int k = 0; k < 8; k++) begin
         #1 chk("wd_quiet", {err_o, busy_o, dm_rvalid_o, dm_gnt_o}, 4'b0100);
         step;
      end
`ifdef ARB_TIMEOUT_EN
      #1 chk("wd_abort", {err_o, dm_gnt_o, dm_rvalid_o, busy_o}, 4'b1111);
      chk("wd_rdata", dm_rdata_o, 0);
      step;
      #1 chk("wd_idle", {err_o, busy_o, dm_rvalid_o}, 0);
`else
      for (int k = 0; k < 8; k++) begin
         #1 chk("wd_stay", {err_o, busy_o, dm_rvalid_o}, 3'b010);
         step;
      end
      mem_rvalid_i = 1;
      #1 chk("wd_late_rv", {dm_rvalid_o, dm_rdata_o}, {1'b1, 32'hFFFFFFFF});
      step;
      mem_rvalid_i = 0;
`endif
      rst_i = 1;
      step;
      rst_i = 0;
      ph = 0; wt = 0; cnt = 0; gi = 0; gd = 0; last_if = 0; last_dm = 0;
      m_dm = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_mask = 0;
      for (int c = 0; c < 3000; c++) begin
         step;
         if (gi) if_req_i = 0;
         else if (!if_req_i && $urandom_range(0, 2) == 0) begin
            if_req_i = 1; if_addr_i = $urandom;
         end
         if (gd) dm_req_i = 0;
         else if (!dm_req_i && $urandom_range(0, 2) == 0) begin
            dm_req_i = 1; dm_we_i = 1'($urandom_range(0, 1)); dm_addr_i = $urandom;
            dm_wdata_i = $urandom; dm_wmask_i = 4'($urandom);
         end
         mem_ready_i = $urandom_range(0, 1) == 1 || wt >= 3;
         mem_rvalid_i = $urandom_range(0, 1) == 1 || wt >= 3;
         mem_rdata_i = $urandom;
         #1;
         egi = ph == 1 && mem_ready_i && !m_dm;
         egd = ph == 1 && mem_ready_i && m_dm;
         eri = ph == 2 && mem_rvalid_i && !m_dm;
         erd = ph == 2 && mem_rvalid_i && m_dm;
         chk("rnd_ctl", {busy_o, mem_req_o, if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o, err_o},
             {ph != 0, ph == 1, egi, egd, eri, erd, 1'b0});
         if (ph == 1) begin
            chk("rnd_cmd", {mem_we_o, mem_wmask_o, mem_addr_o}, {e_we, e_mask, e_addr});
            chk("rnd_wdata", mem_wdata_o, e_wdata);
         end
         if (eri) last_if = mem_rdata_i;
         if (erd) last_dm = mem_rdata_i;
         chk("rnd_rdata", {if_rdata_o, dm_rdata_o}, {last_if, last_dm});
         gi = egi; gd = egd;
         if (ph == 0 && (if_req_i || dm_req_i)) begin
            win = dm_req_i && (!if_req_i || cnt < MAXG);
            m_dm = win;
            e_addr = win ? dm_addr_i : if_addr_i;
            e_we = win && dm_we_i;
            e_wdata = win ? dm_wdata_i : 0;
            e_mask = win ? dm_wmask_i : 0;
            if (!if_req_i) cnt = 0;
            ph = 1; wt = 0;
         end else if (egi || egd) begin
            cnt = egi ? 0 : (if_req_i && cnt < MAXG) ? cnt + 1 : cnt;
            ph = e_we ? 0 : 2; wt = 0;
         end else if (eri || erd) begin
            ph = 0; wt = 0;
         end else wt++;
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
